// File: rtl/dispatch_queue_if.sv
// rtl/dispatch_queue_if.sv - fetch, register-file, ROB and dispatch signals of dispatch_queue
// slave is the dispatch queue side; master is the surrounding pipeline.
interface dispatch_queue_if #(
  parameter int ROB_ID_W = 5
);
  logic                _clear;
  logic                _inst_ready_in;
  logic [31:0]         _inst_in;
  logic [31:0]         _inst_addr;
  logic                _iq_full;
  logic                _jump_valid;
  logic [31:0]         _jump_target;
  logic [4:0]          _get_register_id_1;
  logic [4:0]          _get_register_id_2;
  logic                _reg_has_dep_1;
  logic                _reg_has_dep_2;
  logic [ROB_ID_W-1:0] _reg_dep_1;
  logic [ROB_ID_W-1:0] _reg_dep_2;
  logic [31:0]         _reg_value_1;
  logic [31:0]         _reg_value_2;
  logic [ROB_ID_W-1:0] _get_rob_status_1;
  logic [ROB_ID_W-1:0] _get_rob_status_2;
  logic                _rob_register_ready_1;
  logic                _rob_register_ready_2;
  logic [31:0]         _rob_register_value_1;
  logic [31:0]         _rob_register_value_2;
  logic                _rename_valid;
  logic [4:0]          _rename_rd;
  logic [ROB_ID_W-1:0] _rename_tag;
  logic                _rob_full;
  logic                _rs_full;
  logic                _lsb_full;
  logic [ROB_ID_W-1:0] _rob_tail_id;
  logic                _rob_ready;
  logic                _rs_ready;
  logic                _lsb_ready;
  logic [4:0]          _disp_op;
  logic [2:0]          _disp_funct3;
  logic                _disp_funct7b5;
  logic [ROB_ID_W-1:0] _disp_rob_id;
  logic [4:0]          _disp_rd;
  logic [31:0]         _disp_pc;
  logic [31:0]         _disp_imm;
  logic                _disp_has_dep_1;
  logic                _disp_has_dep_2;
  logic [ROB_ID_W-1:0] _disp_dep_1;
  logic [ROB_ID_W-1:0] _disp_dep_2;
  logic [31:0]         _disp_val_1;
  logic [31:0]         _disp_val_2;
  logic                _disp_illegal;

  modport slave (
    input  _clear, _inst_ready_in, _inst_in, _inst_addr,
    input  _reg_has_dep_1, _reg_has_dep_2, _reg_dep_1, _reg_dep_2, _reg_value_1, _reg_value_2,
    input  _rob_register_ready_1, _rob_register_ready_2, _rob_register_value_1, _rob_register_value_2,
    input  _rob_full, _rs_full, _lsb_full, _rob_tail_id,
    output _iq_full, _jump_valid, _jump_target, _get_register_id_1, _get_register_id_2,
    output _get_rob_status_1, _get_rob_status_2, _rename_valid, _rename_rd, _rename_tag,
    output _rob_ready, _rs_ready, _lsb_ready, _disp_op, _disp_funct3, _disp_funct7b5,
    output _disp_rob_id, _disp_rd, _disp_pc, _disp_imm, _disp_has_dep_1, _disp_has_dep_2,
    output _disp_dep_1, _disp_dep_2, _disp_val_1, _disp_val_2, _disp_illegal
  );

  modport master (
    output _clear, _inst_ready_in, _inst_in, _inst_addr,
    output _reg_has_dep_1, _reg_has_dep_2, _reg_dep_1, _reg_dep_2, _reg_value_1, _reg_value_2,
    output _rob_register_ready_1, _rob_register_ready_2, _rob_register_value_1, _rob_register_value_2,
    output _rob_full, _rs_full, _lsb_full, _rob_tail_id,
    input  _iq_full, _jump_valid, _jump_target, _get_register_id_1, _get_register_id_2,
    input  _get_rob_status_1, _get_rob_status_2, _rename_valid, _rename_rd, _rename_tag,
    input  _rob_ready, _rs_ready, _lsb_ready, _disp_op, _disp_funct3, _disp_funct7b5,
    input  _disp_rob_id, _disp_rd, _disp_pc, _disp_imm, _disp_has_dep_1, _disp_has_dep_2,
    input  _disp_dep_1, _disp_dep_2, _disp_val_1, _disp_val_2, _disp_illegal
  );
endinterface

// File: rtl/dispatch_queue.sv
// rtl/dispatch_queue.sv - in-order RV32I instruction queue with head decode and dispatch
// Head entry is decoded combinationally; dispatch results are registered one-cycle pulses.
module dispatch_queue #(
  parameter int QUEUE_DEPTH = 4,
  parameter int ROB_ID_W    = 5
) (
  input logic              clk_in,
  input logic              rst_in,
  input logic              rdy_in,
  dispatch_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);
  localparam int OPND_W = ROB_ID_W + 33;

  logic [31:0]      inst_q [QUEUE_DEPTH];
  logic [31:0]      pc_q   [QUEUE_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic        head_valid, legal, illegal;
  logic [31:0] inst, pc, imm, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [4:0]  op5, rd;
  logic        is_load, is_store, is_branch, is_jal, is_jalr, is_op, is_opimm, is_lui, is_auipc;
  logic        to_rs, to_lsb, uses_rs1, uses_rs2;
  logic        fire, jal_fire, enq;
  logic [OPND_W-1:0] opnd_1, opnd_2;

  logic                rob_ready_q, rs_ready_q, lsb_ready_q, jump_valid_q, illegal_q;
  logic [31:0]         jump_target_q, disp_pc_q, disp_imm_q;
  logic [4:0]          disp_op_q, disp_rd_q;
  logic [2:0]          disp_funct3_q;
  logic                disp_funct7b5_q;
  logic [ROB_ID_W-1:0] disp_rob_id_q;
  logic [OPND_W-1:0]   opnd_1_q, opnd_2_q;

  // Returns {has_dep, dep, val}; an unused operand resolves to all zeros.
  function automatic logic [OPND_W-1:0] resolve(input logic used, input logic has_dep,
                                                input logic [ROB_ID_W-1:0] dep, input logic [31:0] val,
                                                input logic rob_rdy, input logic [31:0] rob_val);
    if (!used)         return '0;
    else if (!has_dep) return {1'b0, {ROB_ID_W{1'b0}}, val};
    else if (rob_rdy)  return {1'b0, {ROB_ID_W{1'b0}}, rob_val};
    else               return {1'b1, dep, 32'h0};
  endfunction

  assign head_valid = (count_q != '0);
  assign inst       = inst_q[head_q];
  assign pc         = pc_q[head_q];
  assign op5        = inst[6:2];
  assign legal      = (inst[1:0] == 2'b11);

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'h0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    is_load   = legal && (op5 == 5'b00000);
    is_opimm  = legal && (op5 == 5'b00100);
    is_auipc  = legal && (op5 == 5'b00101);
    is_store  = legal && (op5 == 5'b01000);
    is_op     = legal && (op5 == 5'b01100);
    is_lui    = legal && (op5 == 5'b01101);
    is_branch = legal && (op5 == 5'b11000);
    is_jalr   = legal && (op5 == 5'b11001);
    is_jal    = legal && (op5 == 5'b11011);
    to_lsb    = is_load || is_store;
    to_rs     = is_op || is_opimm || is_branch || is_jalr || is_lui || is_auipc;
    illegal   = !(to_lsb || to_rs || is_jal);
    uses_rs1  = is_load || is_store || is_op || is_opimm || is_branch || is_jalr;
    uses_rs2  = is_store || is_op || is_branch;
    rd        = (is_branch || is_store) ? 5'd0 : inst[11:7];
    imm       = 32'h0;
    if (is_load || is_opimm || is_jalr) imm = imm_i;
    else if (is_store)                  imm = imm_s;
    else if (is_branch)                 imm = imm_b;
    else if (is_lui || is_auipc)        imm = imm_u;
    else if (is_jal)                    imm = pc + 32'd4;
  end

  assign opnd_1 = resolve(uses_rs1, bus._reg_has_dep_1, bus._reg_dep_1, bus._reg_value_1,
                          bus._rob_register_ready_1, bus._rob_register_value_1);
  assign opnd_2 = resolve(uses_rs2, bus._reg_has_dep_2, bus._reg_dep_2, bus._reg_value_2,
                          bus._rob_register_ready_2, bus._rob_register_value_2);

  assign fire = !rst_in && rdy_in && !bus._clear && head_valid && !bus._rob_full &&
                !(to_rs && bus._rs_full) && !(to_lsb && bus._lsb_full);
  assign jal_fire = fire && is_jal;
  assign enq = !rst_in && rdy_in && !bus._clear && !jal_fire && bus._inst_ready_in && !bus._iq_full;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy_in) begin
      if (bus._clear || jal_fire) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (fire) head_d = head_q + 1'b1;
        if (enq)  tail_d = tail_q + 1'b1;
        count_d = count_q + CNT_W'(enq) - CNT_W'(fire);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (enq) begin
      inst_q[tail_q] <= bus._inst_in;
      pc_q[tail_q]   <= bus._inst_addr;
    end
  end

  // Pulses follow fire every cycle; the payload holds its last dispatched value.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rob_ready_q     <= 1'b0;
      rs_ready_q      <= 1'b0;
      lsb_ready_q     <= 1'b0;
      jump_valid_q    <= 1'b0;
      jump_target_q   <= 32'h0;
      disp_op_q       <= 5'd0;
      disp_funct3_q   <= 3'd0;
      disp_funct7b5_q <= 1'b0;
      disp_rob_id_q   <= '0;
      disp_rd_q       <= 5'd0;
      disp_pc_q       <= 32'h0;
      disp_imm_q      <= 32'h0;
      opnd_1_q        <= '0;
      opnd_2_q        <= '0;
      illegal_q       <= 1'b0;
    end else begin
      rob_ready_q  <= fire;
      rs_ready_q   <= fire && to_rs;
      lsb_ready_q  <= fire && to_lsb;
      jump_valid_q <= jal_fire;
      if (jal_fire) jump_target_q <= pc + imm_j;
      if (fire) begin
        disp_op_q       <= op5;
        disp_funct3_q   <= inst[14:12];
        disp_funct7b5_q <= inst[30];
        disp_rob_id_q   <= bus._rob_tail_id;
        disp_rd_q       <= rd;
        disp_pc_q       <= pc;
        disp_imm_q      <= imm;
        opnd_1_q        <= opnd_1;
        opnd_2_q        <= opnd_2;
        illegal_q       <= illegal;
      end
    end
  end

  assign bus._iq_full           = (count_q == DEPTH_C);
  assign bus._get_register_id_1 = head_valid ? inst[19:15] : 5'd0;
  assign bus._get_register_id_2 = head_valid ? inst[24:20] : 5'd0;
  assign bus._get_rob_status_1  = bus._reg_dep_1;
  assign bus._get_rob_status_2  = bus._reg_dep_2;
  assign bus._rename_valid      = fire && (rd != 5'd0);
  assign bus._rename_rd         = bus._rename_valid ? rd : 5'd0;
  assign bus._rename_tag        = bus._rename_valid ? bus._rob_tail_id : '0;
  assign bus._rob_ready         = rob_ready_q;
  assign bus._rs_ready          = rs_ready_q;
  assign bus._lsb_ready         = lsb_ready_q;
  assign bus._jump_valid        = jump_valid_q;
  assign bus._jump_target       = jump_target_q;
  assign bus._disp_op           = disp_op_q;
  assign bus._disp_funct3       = disp_funct3_q;
  assign bus._disp_funct7b5     = disp_funct7b5_q;
  assign bus._disp_rob_id       = disp_rob_id_q;
  assign bus._disp_rd           = disp_rd_q;
  assign bus._disp_pc           = disp_pc_q;
  assign bus._disp_imm          = disp_imm_q;
  assign bus._disp_has_dep_1    = opnd_1_q[OPND_W-1];
  assign bus._disp_dep_1        = opnd_1_q[OPND_W-2:32];
  assign bus._disp_val_1        = opnd_1_q[31:0];
  assign bus._disp_has_dep_2    = opnd_2_q[OPND_W-1];
  assign bus._disp_dep_2        = opnd_2_q[OPND_W-2:32];
  assign bus._disp_val_2        = opnd_2_q[31:0];
  assign bus._disp_illegal      = illegal_q;
endmodule
